// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, serviced
// after WAIT_CYCLES wait states, with size/alignment/range checking.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [2:0]            op_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  stall_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    we_q;
  logic [IDX_W+1:0]        addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [2:0]              op_q;

  logic [31:0]             mem [DEPTH_WORDS];

  logic                    req_err;
  logic                    access;
  logic [IDX_W-1:0]        word_idx;
  logic [31:0]             rd_word;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [31:0]             load_val;
  logic [3:0]              wbe;
  logic [31:0]             wdata;

  // Reject reserved sizes, misaligned halves/words and anything past the array end.
  always_comb begin
    req_err = 1'b0;
    case (op_i[1:0])
      2'b01:   req_err = addr_i[0];
      2'b10:   req_err = |addr_i[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ((addr_i >> (IDX_W + 2)) != '0) req_err = 1'b1;
  end

  assign access   = rst_i && (state == WAIT) && (cnt == 4'd0);
  assign word_idx = addr_q[IDX_W+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    rd_byte = 8'h00;
    case (addr_q[1:0])
      2'b00: rd_byte = rd_word[7:0];
      2'b01: rd_byte = rd_word[15:8];
      2'b10: rd_byte = rd_word[23:16];
      2'b11: rd_byte = rd_word[31:24];
      default: rd_byte = 8'h00;
    endcase
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    case (op_q[1:0])
      2'b00: load_val = op_q[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01: load_val = op_q[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    wbe   = 4'b1111;
    wdata = data_q;
    case (op_q[1:0])
      2'b00: begin
        wbe   = 4'b0001 << addr_q[1:0];
        wdata = {4{data_q[7:0]}};
      end
      2'b01: begin
        wbe   = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_q[15:0]}};
      end
      default: begin
        wbe   = 4'b1111;
        wdata = data_q;
      end
    endcase
  end

  // The array is never reset; writes happen only on the final wait-state edge.
  always_ff @(posedge clk_i) begin
    if (access && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= 3'b000;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_o   <= 1'b0;
          err_o   <= 1'b0;
          rdata_o <= '0;
          if (req_i) begin
            we_q   <= we_i;
            addr_q <= addr_i[IDX_W+1:0];
            data_q <= data_i;
            op_q   <= op_i;
            if (req_err) begin
              state <= RESP;
              ack_o <= 1'b1;
              err_o <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= RESP;
            ack_o   <= 1'b1;
            err_o   <= 1'b0;
            rdata_o <= we_q ? '0 : load_val;
          end
        end
        RESP: begin
          state   <= IDLE;
          ack_o   <= 1'b0;
          err_o   <= 1'b0;
          rdata_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Released in RESP so the pipeline advances during the ack cycle.
  assign stall_o = rst_i && ((state == WAIT) || ((state == IDLE) && req_i));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-array reference model plus a per-cycle
// compare process that checks ack/err/rdata/stall against scheduled expectations.
module tb_dmem_responder;

  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  op = 3'b000;
  logic        ack;
  logic        err;
  logic        stall;
  logic [31:0] rdata;

  dmem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .data_i (wdata),
    .op_i   (op),
    .ack_o  (ack),
    .rdata_o(rdata),
    .err_o  (err),
    .stall_o(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] rdata;
    bit          we;
    int          addr;
    logic [31:0] wdata;
    int          nbytes;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  mm [0:4095];
  int          cyc = 0;
  int          stall_lo = 1;
  int          stall_hi = 0;
  int          issue_cyc = 0;
  int          last_ack_cyc = -100;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;
  int          total = 0;
  int          passed = 0;
  int          lat_unused;
  int          ack1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic logic [31:0] model_load(input int a, input int nb, input bit uns);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(mm[a+i]) << (8*i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
    return v;
  endfunction

  // Present a request in the current cycle and schedule its expected response.
  task automatic applyStimulus(input bit w, input int a, input logic [31:0] d,
                               input logic [2:0] o, output int lat);
    exp_t e;
    int   nb;
    bit   bad;
    nb  = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
    bad = (o[1:0] == 2'b11) || (nb == 2 && (a % 2) != 0) || (nb == 4 && (a % 4) != 0) || (a >= 4096);
    lat = bad ? 1 : WAIT_CYCLES + 2;
    req = 1'b1;
    we = w;
    addr = 32'(a);
    wdata = d;
    op = o;
    e.cyc    = cyc + lat;
    e.err    = bad;
    e.rdata  = (bad || w) ? 32'h0 : model_load(a, nb, o[2]);
    e.we     = w && !bad;
    e.addr   = a;
    e.wdata  = d;
    e.nbytes = nb;
    expq.push_back(e);
    stall_lo     = cyc;
    stall_hi     = cyc + lat - 1;
    issue_cyc    = cyc;
    last_ack_cyc = -100;
  endtask

  task automatic do_req(input bit w, input int a, input logic [31:0] d,
                        input logic [2:0] o, input bit hold);
    int lat;
    applyStimulus(w, a, d, o, lat);
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    repeat (lat) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare; the model memory is committed only when a response is due.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_ack;
    exp_ack = 1'b0;
    if (!rst_n) begin
      checkOutput("rst_ack", 32'(ack), 32'h0);
      checkOutput("rst_err", 32'(err), 32'h0);
      checkOutput("rst_rdata", rdata, 32'h0);
      checkOutput("rst_stall", 32'(stall), 32'h0);
    end else begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        exp_ack = 1'b1;
        if (e.we) begin
          for (int i = 0; i < e.nbytes; i++) mm[e.addr+i] = e.wdata[8*i +: 8];
        end
      end
      checkOutput("ack", 32'(ack), 32'(exp_ack));
      if (exp_ack) begin
        checkOutput("err", 32'(err), 32'(e.err));
        checkOutput("rdata", rdata, e.rdata);
      end
      checkOutput("stall", 32'(stall), 32'(cyc >= stall_lo && cyc <= stall_hi));
      if (ack === 1'b1) begin
        last_ack_cyc = cyc;
        last_err     = err;
        last_rdata   = rdata;
      end
    end
  end

  initial begin
    // Reset with a request pending: stall must stay low.
    rst_n = 1'b0;
    req = 1'b1;
    op = 3'b010;
    addr = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_req(1'b1, 'h100, 32'hDEADBEEF, 3'b010, 1'b0);
    checkOutput("sw_latency", 32'(last_ack_cyc - issue_cyc), 32'd4);
    checkOutput("sw_err", 32'(last_err), 32'h0);
    do_req(1'b0, 'h100, 32'h0, 3'b010, 1'b0);
    checkOutput("lw_100", last_rdata, 32'hDEADBEEF);
    checkOutput("lw_latency", 32'(last_ack_cyc - issue_cyc), 32'd4);

    do_req(1'b1, 'h200, 32'h0, 3'b010, 1'b0);
    do_req(1'b1, 'h203, 32'h000000A5, 3'b000, 1'b0);
    do_req(1'b0, 'h203, 32'h0, 3'b000, 1'b0);
    checkOutput("lb_203", last_rdata, 32'hFFFFFFA5);
    do_req(1'b0, 'h203, 32'h0, 3'b100, 1'b0);
    checkOutput("lbu_203", last_rdata, 32'h000000A5);
    do_req(1'b0, 'h200, 32'h0, 3'b010, 1'b0);
    checkOutput("lw_200", last_rdata, 32'hA5000000);
    do_req(1'b1, 'h202, 32'h00008001, 3'b001, 1'b0);
    do_req(1'b0, 'h202, 32'h0, 3'b001, 1'b0);
    checkOutput("lh_202", last_rdata, 32'hFFFF8001);
    do_req(1'b0, 'h202, 32'h0, 3'b101, 1'b0);
    checkOutput("lhu_202", last_rdata, 32'h00008001);

    do_req(1'b0, 'h102, 32'h0, 3'b010, 1'b0);
    checkOutput("misalign_err", 32'(last_err), 32'h1);
    checkOutput("misalign_latency", 32'(last_ack_cyc - issue_cyc), 32'd1);
    checkOutput("misalign_rdata", last_rdata, 32'h0);
    do_req(1'b1, 'h201, 32'h00001234, 3'b001, 1'b0);
    checkOutput("sh_misalign_err", 32'(last_err), 32'h1);
    do_req(1'b0, 'h200, 32'h0, 3'b010, 1'b0);
    checkOutput("lw_200_unchanged", last_rdata, 32'h80010000);
    do_req(1'b1, 'h1000, 32'h11111111, 3'b010, 1'b0);
    checkOutput("range_err", 32'(last_err), 32'h1);
    do_req(1'b0, 'h200, 32'h0, 3'b011, 1'b0);
    checkOutput("size11_err", 32'(last_err), 32'h1);

    // Abort a store in WAIT with cnt=1; the array must keep its old word.
    do_req(1'b1, 'h300, 32'h0, 3'b010, 1'b0);
    applyStimulus(1'b1, 'h300, 32'h12345678, 3'b010, lat_unused);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expq.delete();
    stall_lo = 1;
    stall_hi = 0;
    #1;
    checkOutput("abort_ack", 32'(ack), 32'h0);
    checkOutput("abort_stall", 32'(stall), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b0, 'h300, 32'h0, 3'b010, 1'b0);
    checkOutput("lw_300_after_abort", last_rdata, 32'h0);

    // Back-to-back: req held through the first ack, next request right after.
    do_req(1'b1, 'h10, 32'hCAFEF00D, 3'b010, 1'b1);
    ack1 = last_ack_cyc;
    do_req(1'b0, 'h10, 32'h0, 3'b010, 1'b0);
    checkOutput("b2b_spacing", 32'(last_ack_cyc - ack1), 32'(WAIT_CYCLES + 3));
    checkOutput("b2b_rdata", last_rdata, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pending_responses", 32'(expq.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
